mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single word-granular backing-memory interface between the instruction cache (port IC) and the data cache (port DC). It sits between the two cache instances and external memory. It forwards one transaction at a time, with round-robin fairness. It allows at most one outstanding read, and routes each read response back to the port that issued it.

## Interface
- `RST_PRI`, default 0: port favoured after reset (0 = IC, 1 = DC).
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_ic_addr` / `i_dc_addr`  in  32  word-aligned request address from each cache.
- `i_ic_ren` / `i_dc_ren`  in  1  read request, held until accepted.
- `i_ic_wen` / `i_dc_wen`  in  1  write request, held until accepted.
- `i_ic_wdata` / `i_dc_wdata`  in  32  write data.
- `o_ic_ready` / `o_dc_ready`  out  1  request accepted this cycle when ready & (ren|wen).
- `o_ic_rdata` / `o_dc_rdata`  out  32  read data; both ports carry `i_mem_rdata`.
- `o_ic_valid` / `o_dc_valid`  out  1  read response for this port.
- `i_mem_ready`  in  1  memory can accept a request.
- `o_mem_addr`  out  32  forwarded address.
- `o_mem_ren`  out  1  forwarded read enable.
- `o_mem_wen`  out  1  forwarded write enable.
- `o_mem_wdata`  out  32  forwarded write data.
- `i_mem_rdata`  in  32  memory read data.
- `i_mem_valid`  in  1  memory read data valid.

## Operation
- Registered state: `state` ∈ {IDLE, RD_WAIT}, `owner` (1 bit), `pri` (1 bit, the port that wins a tie).
- Winner selection in IDLE is combinational:
  - If exactly one port requests (ren|wen), that port wins.
  - If both request, the port `pri` wins.
  - If no port requests, there is no winner and all `o_mem_*` enables are 0.
- The winner's addr, ren, wen and wdata drive `o_mem_*`.
- Winner's `o_*_ready` = `i_mem_ready`. The loser's ready = 0.
- When a port asserts ren and wen together, ren is forwarded and wen is dropped (illegal input).
- Write accept (winner wen & `i_mem_ready`):
  - Completes on the accepting edge; there is no response.
  - State stays IDLE.
  - `pri` ← other port.
- Read accept (winner ren & `i_mem_ready`):
  - `owner` ← winner.
  - State → RD_WAIT.
- RD_WAIT:
  - `o_mem_ren` = `o_mem_wen` = 0; both ready outputs = 0.
  - `o_<owner>_valid` = `i_mem_valid`; the other port's valid = 0.
  - On `i_mem_valid`: state → IDLE, `pri` ← other port than `owner`.
- `i_mem_valid` in IDLE is ignored; no port sees valid.
- Reset:
  - state = IDLE, `pri` = `RST_PRI`, `owner` = 0, lock counter = 0.
  - While `i_rst` is high, all ready, valid and `o_mem_ren`/`o_mem_wen` outputs are 0.
- Reset mid-read: the outstanding read is abandoned. A later `i_mem_valid` arrives in IDLE and is dropped.

## Timing
- Hit-free accept latency is 0 cycles: a request and `i_mem_ready` in the same cycle are accepted at that edge.
- A read response reaches the owner in the same cycle as `i_mem_valid` (combinational pass-through).
- The earliest next accept is the cycle after `i_mem_valid`.
- Back-to-back writes can be accepted every cycle. Writes alternate between ports when both request.
- The only combinational paths are request→`o_mem_*`, `i_mem_ready`→ready, and `i_mem_valid`→valid. No path runs from `i_mem_*` back to `o_mem_*`.

## Configuration
- `MEM_ARB_LINE_LOCK_EN` defined:
  - A read accepted from port P while the lock counter is 0 loads the counter with 3 and sets lock owner = P.
  - While the counter is nonzero, P wins every IDLE arbitration regardless of `pri`.
  - Each further read accepted from P decrements the counter.
  - The lock is released (counter ← 0) if P requests nothing for one full IDLE cycle, or on a write from P.
  - `pri` is updated only when the counter reaches 0.
  - Effect: a 4-word line fill is never interleaved with the other cache.
- Not defined: the counter logic is absent and arbitration is per word.

## Test plan
- Reset, RST_PRI=0, both ports request a read in the same cycle, `i_mem_ready`=1 → IC accepted; `o_mem_addr`=IC addr; DC ready=0.
- IC read of 0x100; memory returns 0xDEADBEEF after 3 cycles → `o_ic_valid` pulses once with rdata 0xDEADBEEF; `o_dc_valid` stays 0; DC read accepted on the next cycle.
- Both ports issue continuous writes, `i_mem_ready`=1 → accepts alternate IC, DC, IC, DC; no cycle has both ready outputs high.
- `i_mem_ready`=0 for 5 cycles with DC wen held → `o_mem_wen`=1 and addr stable for all 5 cycles; accepted on the cycle ready rises.
- `i_rst` asserted during RD_WAIT; `i_mem_valid` arrives 2 cycles after deassert → no port sees valid; the next request is accepted normally.
- With `MEM_ARB_LINE_LOCK_EN`: DC reads 0x200, 0x204, 0x208, 0x20C while IC requests continuously → all 4 DC reads are served before IC. Without the macro, IC is served between DC reads.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-granular memory port between IC and DC, one read outstanding.
// Optional `MEM_ARB_LINE_LOCK_EN keeps a read owner locked for a 4-word line fill.
module mem_arbiter #(
  parameter logic RST_PRI = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ic_addr,
  input  logic        i_ic_ren,
  input  logic        i_ic_wen,
  input  logic [31:0] i_ic_wdata,
  output logic        o_ic_ready,
  output logic [31:0] o_ic_rdata,
  output logic        o_ic_valid,
  input  logic [31:0] i_dc_addr,
  input  logic        i_dc_ren,
  input  logic        i_dc_wen,
  input  logic [31:0] i_dc_wdata,
  output logic        o_dc_ready,
  output logic [31:0] o_dc_rdata,
  output logic        o_dc_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RD_WAIT = 1'b1} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   pri_q, pri_d;
  logic   ic_req_s, dc_req_s;
  logic   win_vld_s, win_dc_s, win_ren_s, win_wen_s, accept_s;
  logic   lock_act_s, lock_dc_s, lock_zero_s;

`ifdef MEM_ARB_LINE_LOCK_EN
  logic [1:0] lock_cnt_q, lock_cnt_d, cnt_eff_s;
  logic       lock_dc_q, lock_dc_d, p_req_s;

  assign lock_act_s  = (lock_cnt_q != 2'd0);
  assign lock_dc_s   = lock_dc_q;
  assign lock_zero_s = (lock_cnt_q == 2'd0);

  // An idle cycle without a request from the lock owner releases the lock before the accept is judged.
  always_comb begin
    p_req_s    = lock_dc_q ? dc_req_s : ic_req_s;
    cnt_eff_s  = lock_cnt_q;
    lock_cnt_d = lock_cnt_q;
    lock_dc_d  = lock_dc_q;
    if (state_q == S_IDLE) begin
      if (!p_req_s) begin
        cnt_eff_s = 2'd0;
      end else begin
        cnt_eff_s = lock_cnt_q;
      end
      if (accept_s && win_ren_s) begin
        if (cnt_eff_s == 2'd0) begin
          lock_cnt_d = 2'd3;
          lock_dc_d  = win_dc_s;
        end else begin
          lock_cnt_d = cnt_eff_s - 2'd1;
        end
      end else if (accept_s) begin
        lock_cnt_d = 2'd0;
      end else begin
        lock_cnt_d = cnt_eff_s;
      end
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_cnt_q <= 2'd0;
      lock_dc_q  <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_dc_q  <= lock_dc_d;
    end
  end
`else
  assign lock_act_s  = 1'b0;
  assign lock_dc_s   = 1'b0;
  assign lock_zero_s = 1'b1;
`endif

  // Winner selection; a port driving ren and wen together is treated as a read.
  always_comb begin
    ic_req_s  = i_ic_ren | i_ic_wen;
    dc_req_s  = i_dc_ren | i_dc_wen;
    win_vld_s = 1'b0;
    win_dc_s  = 1'b0;
    if (state_q == S_IDLE) begin
      win_vld_s = ic_req_s | dc_req_s;
      if (ic_req_s && dc_req_s) begin
        win_dc_s = lock_act_s ? lock_dc_s : pri_q;
      end else begin
        win_dc_s = dc_req_s;
      end
    end else begin
      win_vld_s = 1'b0;
    end
    win_ren_s = win_dc_s ? i_dc_ren : i_ic_ren;
    win_wen_s = (win_dc_s ? i_dc_wen : i_ic_wen) & ~win_ren_s;
    accept_s  = win_vld_s & i_mem_ready;
  end

  assign o_mem_addr  = win_dc_s ? i_dc_addr : i_ic_addr;
  assign o_mem_wdata = win_dc_s ? i_dc_wdata : i_ic_wdata;
  assign o_mem_ren   = win_vld_s & win_ren_s & ~i_rst;
  assign o_mem_wen   = win_vld_s & win_wen_s & ~i_rst;
  assign o_ic_ready  = win_vld_s & ~win_dc_s & i_mem_ready & ~i_rst;
  assign o_dc_ready  = win_vld_s & win_dc_s & i_mem_ready & ~i_rst;
  assign o_ic_rdata  = i_mem_rdata;
  assign o_dc_rdata  = i_mem_rdata;
  assign o_ic_valid  = (state_q == S_RD_WAIT) & ~owner_q & i_mem_valid & ~i_rst;
  assign o_dc_valid  = (state_q == S_RD_WAIT) & owner_q & i_mem_valid & ~i_rst;

  // Next-state logic: priority flips only once a lock (if any) has run down.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pri_d   = pri_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && win_ren_s) begin
          state_d = S_RD_WAIT;
          owner_d = win_dc_s;
        end else if (accept_s) begin
          pri_d = ~win_dc_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (i_mem_valid) begin
          state_d = S_IDLE;
          if (lock_zero_s) begin
            pri_d = ~owner_q;
          end else begin
            pri_d = pri_q;
          end
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      pri_q   <= RST_PRI;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pri_q   <= pri_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs change 1 ns after posedge, outputs sampled 4 ns after posedge.
module tb_mem_arbiter;

  logic        clk, rst;
  logic [31:0] ic_addr, ic_wdata, ic_rdata, dc_addr, dc_wdata, dc_rdata;
  logic        ic_ren, ic_wen, ic_ready, ic_valid, dc_ren, dc_wen, dc_ready, dc_valid;
  logic        mem_ready, mem_ren, mem_wen, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          errors = 0;
  int          checks = 0;

  mem_arbiter #(.RST_PRI(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_addr(ic_addr), .i_ic_ren(ic_ren), .i_ic_wen(ic_wen), .i_ic_wdata(ic_wdata),
    .o_ic_ready(ic_ready), .o_ic_rdata(ic_rdata), .o_ic_valid(ic_valid),
    .i_dc_addr(dc_addr), .i_dc_ren(dc_ren), .i_dc_wen(dc_wen), .i_dc_wdata(dc_wdata),
    .o_dc_ready(dc_ready), .o_dc_rdata(dc_rdata), .o_dc_valid(dc_valid),
    .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_addr = 32'h0; ic_wdata = 32'h0; ic_ren = 1'b0; ic_wen = 1'b0;
    dc_addr = 32'h0; dc_wdata = 32'h0; dc_ren = 1'b0; dc_wen = 1'b0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ic_ren = 1'b1; dc_wen = 1'b1; mem_ready = 1'b1; mem_valid = 1'b1;
    #3;
    checks++;
    if ({ic_ready, dc_ready, mem_ren, mem_wen, ic_valid, dc_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 000000", {ic_ready, dc_ready, mem_ren, mem_wen, ic_valid, dc_valid});
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_tie_read();
    ic_addr = 32'h100; ic_ren = 1'b1; dc_addr = 32'h300; dc_ren = 1'b1; mem_ready = 1'b1;
    #3;
    checks++;
    if ({ic_ready, dc_ready, mem_ren, mem_wen} !== 4'b1010) begin
      errors++;
      $display("FAIL tie_read_grant: got ic/dc/ren/wen=%b, want 1010", {ic_ready, dc_ready, mem_ren, mem_wen});
    end
    checks++;
    if (mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL tie_read_addr: got %h, want 00000100", mem_addr);
    end
    tick();
    ic_ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if ({mem_ren, dc_ready, ic_valid, dc_valid} !== 4'b0000) begin
        errors++;
        $display("FAIL rd_wait_quiet[%0d]: got %b, want 0000", i, {mem_ren, dc_ready, ic_valid, dc_valid});
      end
      tick();
    end
    mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #3;
    checks++;
    if ({ic_valid, dc_valid} !== 2'b10 || ic_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ic_response: got valid=%b rdata=%h, want 10 deadbeef", {ic_valid, dc_valid}, ic_rdata);
    end
    tick();
    mem_valid = 1'b0;
    #3;
    checks++;
    if ({ic_ready, dc_ready, ic_valid} !== 3'b010 || mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL dc_next_accept: got rdy/val=%b addr=%h, want 010 00000300", {ic_ready, dc_ready, ic_valid}, mem_addr);
    end
    tick();
    dc_ren = 1'b0;
    mem_valid = 1'b1; mem_rdata = 32'h12345678;
    #3;
    checks++;
    if ({ic_valid, dc_valid} !== 2'b01 || dc_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL dc_response: got valid=%b rdata=%h, want 01 12345678", {ic_valid, dc_valid}, dc_rdata);
    end
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_dc;
    apply_reset();
    ic_wen = 1'b1; dc_wen = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ic_addr = 32'h1000 + 32'(i * 4); ic_wdata = 32'hA0 + 32'(i);
      dc_addr = 32'h2000 + 32'(i * 4); dc_wdata = 32'hB0 + 32'(i);
      exp_dc = (i % 2) == 1;
      #3;
      checks++;
      if ({ic_ready, dc_ready, mem_wen, mem_ren} !== {~exp_dc, exp_dc, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got ic/dc/wen/ren=%b, want %b", i, {ic_ready, dc_ready, mem_wen, mem_ren}, {~exp_dc, exp_dc, 2'b10});
      end
      checks++;
      if (mem_addr !== (exp_dc ? dc_addr : ic_addr) || mem_wdata !== (exp_dc ? dc_wdata : ic_wdata)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got addr=%h wdata=%h, want %h %h", i, mem_addr, mem_wdata, exp_dc ? dc_addr : ic_addr, exp_dc ? dc_wdata : ic_wdata);
      end
      tick();
    end
    ic_wen = 1'b0; dc_wen = 1'b0;
  endtask

  task automatic test_mem_stall();
    mem_ready = 1'b0; dc_wen = 1'b1; dc_addr = 32'h400; dc_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (mem_wen !== 1'b1 || mem_addr !== 32'h400 || dc_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got wen=%b addr=%h ready=%b, want 1 00000400 0", i, mem_wen, mem_addr, dc_ready);
      end
      tick();
    end
    mem_ready = 1'b1;
    #3;
    checks++;
    if (dc_ready !== 1'b1 || mem_wdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL stall_release: got ready=%b wdata=%h, want 1 a5a5a5a5", dc_ready, mem_wdata);
    end
    tick();
    dc_wen = 1'b0;
  endtask

  task automatic test_illegal_and_idle_valid();
    mem_ready = 1'b0; ic_ren = 1'b1; ic_wen = 1'b1; ic_addr = 32'h500;
    #3;
    checks++;
    if ({mem_ren, mem_wen} !== 2'b10) begin
      errors++;
      $display("FAIL ren_wen_both: got ren/wen=%b, want 10", {mem_ren, mem_wen});
    end
    tick();
    ic_ren = 1'b0; ic_wen = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h55;
    #3;
    checks++;
    if ({ic_valid, dc_valid, mem_ren, mem_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_valid_ignored: got %b, want 0000", {ic_valid, dc_valid, mem_ren, mem_wen});
    end
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    mem_ready = 1'b1; ic_ren = 1'b1; ic_addr = 32'h600;
    #3;
    checks++;
    if (ic_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_accept: got %b, want 1", ic_ready);
    end
    tick();
    ic_ren = 1'b0; rst = 1'b1; mem_valid = 1'b1;
    #3;
    checks++;
    if ({ic_valid, dc_valid, ic_ready, dc_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_read_in_reset: got %b, want 0000", {ic_valid, dc_valid, ic_ready, dc_ready});
    end
    tick();
    rst = 1'b0; mem_valid = 1'b0;
    tick();
    tick();
    mem_valid = 1'b1; mem_rdata = 32'h77;
    #3;
    checks++;
    if ({ic_valid, dc_valid} !== 2'b00) begin
      errors++;
      $display("FAIL stale_valid_dropped: got %b, want 00", {ic_valid, dc_valid});
    end
    tick();
    mem_valid = 1'b0; dc_wen = 1'b1; dc_addr = 32'h700;
    #3;
    checks++;
    if ({dc_ready, mem_wen} !== 2'b11 || mem_addr !== 32'h700) begin
      errors++;
      $display("FAIL post_reset_accept: got rdy/wen=%b addr=%h, want 11 00000700", {dc_ready, mem_wen}, mem_addr);
    end
    tick();
    dc_wen = 1'b0;
  endtask

  task automatic test_line_fill();
    logic exp_seq [6];
    int   nsteps;
    int   dc_idx;
    logic exp_dc;
`ifdef MEM_ARB_LINE_LOCK_EN
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    nsteps = 4;
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    nsteps = 6;
`endif
    apply_reset();
    mem_ready = 1'b1; dc_ren = 1'b1; dc_addr = 32'h200;
    #3;
    checks++;
    if (dc_ready !== 1'b1 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL fill_first: got ready=%b addr=%h, want 1 00000200", dc_ready, mem_addr);
    end
    tick();
    ic_ren = 1'b1; ic_addr = 32'h100; dc_addr = 32'h204; mem_valid = 1'b1;
    #3;
    checks++;
    if ({ic_valid, dc_valid, ic_ready} !== 3'b010) begin
      errors++;
      $display("FAIL fill_first_resp: got %b, want 010", {ic_valid, dc_valid, ic_ready});
    end
    tick();
    mem_valid = 1'b0;
    dc_idx = 1;
    for (int s = 0; s < nsteps; s++) begin
      exp_dc = exp_seq[s];
      #3;
      checks++;
      if ({ic_ready, dc_ready} !== {~exp_dc, exp_dc} || mem_addr !== (exp_dc ? 32'h200 + 32'(dc_idx * 4) : 32'h100)) begin
        errors++;
        $display("FAIL fill_order[%0d]: got ic/dc=%b addr=%h, want %b %h", s, {ic_ready, dc_ready}, mem_addr, {~exp_dc, exp_dc}, exp_dc ? 32'h200 + 32'(dc_idx * 4) : 32'h100);
      end
      tick();
      if (exp_dc) begin
        dc_idx++;
        if (dc_idx == 4) dc_ren = 1'b0;
        else dc_addr = 32'h200 + 32'(dc_idx * 4);
      end
      mem_valid = 1'b1;
      #3;
      checks++;
      if ({ic_valid, dc_valid} !== {~exp_dc, exp_dc}) begin
        errors++;
        $display("FAIL fill_resp[%0d]: got %b, want %b", s, {ic_valid, dc_valid}, {~exp_dc, exp_dc});
      end
      tick();
      mem_valid = 1'b0;
    end
    ic_ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_tie_read();
    test_back_to_back();
    test_mem_stall();
    test_illegal_and_idle_valid();
    test_reset_mid_read();
    test_line_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
